// File: rtl/double_multiply_arbiter_if.sv
// Request/response bus for the shared double-precision multiplier, plus the
// datapath handshake. The arbiter sits on the slave side.
`timescale 1ns/1ps
interface double_multiply_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*64-1:0] req_a;
   logic [NUM_REQ*64-1:0] req_b;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    resp_valid;
   logic [63:0]           resp_z;
   logic [ID_W-1:0]       resp_id;
   logic                  resp_error;
   logic [63:0]           mul_a;
   logic [63:0]           mul_b;
   logic                  mul_valid;
   logic                  mul_reset;
   logic [63:0]           mul_z;
   logic                  mul_done;

   modport master (
      output req_valid, req_a, req_b, mul_z, mul_done,
      input  req_ready, resp_valid, resp_z, resp_id, resp_error,
             mul_a, mul_b, mul_valid, mul_reset
   );

   modport slave (
      input  req_valid, req_a, req_b, mul_z, mul_done,
      output req_ready, resp_valid, resp_z, resp_id, resp_error,
             mul_a, mul_b, mul_valid, mul_reset
   );
endinterface

// File: rtl/double_multiply_arbiter.sv
// Round-robin sharing of one double-precision multiplier datapath, with
// special-operand bypass and a watchdog on every datapath operation.
`timescale 1ns/1ps
module double_multiply_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic                     clock,
   input logic                     reset,
   double_multiply_arbiter_if.slave bus
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] CLEAR   = 3'd1;
   localparam logic [2:0] ISSUE   = 3'd2;
   localparam logic [2:0] WAIT    = 3'd3;
   localparam logic [2:0] RESPOND = 3'd4;

   localparam int          CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [63:0] QNAN  = 64'hFFF8_0000_0000_0000;

   logic [2:0]       state;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  id_q;
   logic [63:0]      op_a;
   logic [63:0]      op_b;
   logic [CNT_W-1:0] tcnt;
   logic [63:0]      resp_z_q;
   logic             resp_err_q;

   logic             grant_hit;
   logic [ID_W-1:0]  grant_id;
   logic [ID_W-1:0]  next_ptr;
   logic [63:0]      sel_a;
   logic [63:0]      sel_b;
   logic [2:0]       cls_a;
   logic [2:0]       cls_b;
   logic             is_special;
   logic [63:0]      bypass_z;

   // {nan, inf, zero}; denormals classify as ordinary operands
   function automatic logic [2:0] classify(input logic [63:0] x);
      logic exp_max;
      logic exp_zero;
      logic man_zero;
      exp_max  = &x[62:52];
      exp_zero = ~|x[62:52];
      man_zero = ~|x[51:0];
      return {exp_max & ~man_zero, exp_max & man_zero, exp_zero & man_zero};
   endfunction

   // First pending requester at or after rr_ptr, wrapping
   always_comb begin
      int unsigned idx;
      idx       = 0;
      grant_hit = 1'b0;
      grant_id  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(rr_ptr) + k) % 32'(NUM_REQ);
         if (!grant_hit && bus.req_valid[idx[ID_W-1:0]]) begin
            grant_hit = 1'b1;
            grant_id  = idx[ID_W-1:0];
         end
      end
   end

   assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
   assign sel_a    = bus.req_a[grant_id*64 +: 64];
   assign sel_b    = bus.req_b[grant_id*64 +: 64];

   always_comb begin
      cls_a      = classify(sel_a);
      cls_b      = classify(sel_b);
      is_special = (|cls_a) | (|cls_b);
      if (cls_a[2] | cls_b[2] | (cls_a[1] & cls_b[0]) | (cls_a[0] & cls_b[1]))
         bypass_z = QNAN;
      else if (cls_a[1] | cls_b[1])
         bypass_z = {sel_a[63] ^ sel_b[63], 11'h7FF, 52'h0};
      else
         bypass_z = {sel_a[63] ^ sel_b[63], 63'h0};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         id_q       <= '0;
         op_a       <= '0;
         op_b       <= '0;
         tcnt       <= '0;
         resp_z_q   <= '0;
         resp_err_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_hit) begin
                  op_a   <= sel_a;
                  op_b   <= sel_b;
                  id_q   <= grant_id;
                  rr_ptr <= next_ptr;
                  if (is_special) begin
                     resp_z_q   <= bypass_z;
                     resp_err_q <= 1'b0;
                     state      <= RESPOND;
                  end else begin
                     state <= CLEAR;
                  end
               end
            end
            CLEAR: state <= ISSUE;
            ISSUE: begin
               tcnt  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               tcnt <= tcnt + 1'b1;
               // done wins over a watchdog expiry in the same cycle
               if (bus.mul_done) begin
                  resp_z_q   <= bus.mul_z;
                  resp_err_q <= 1'b0;
                  state      <= RESPOND;
               end else if (tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  resp_z_q   <= QNAN;
                  resp_err_q <= 1'b1;
                  state      <= RESPOND;
               end
            end
            RESPOND: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state == IDLE && grant_hit && !reset)
                           ? (NUM_REQ'(1) << grant_id) : '0;
   assign bus.resp_valid = (state == RESPOND && !reset)
                           ? (NUM_REQ'(1) << id_q) : '0;
   assign bus.resp_z     = resp_z_q;
   assign bus.resp_id    = id_q;
   assign bus.resp_error = resp_err_q;
   assign bus.mul_a      = op_a;
   assign bus.mul_b      = op_b;
   assign bus.mul_valid  = (state == ISSUE) && !reset;
   assign bus.mul_reset  = reset | (state == CLEAR);

endmodule
